pbit_state_histogram: RTL
=========================

// Module: pbit_state_histogram
// PURPOSE
//  Downstream consumer of the 3-p-bit network: samples the network state {out3,out2,out1}
//  on a strobe and counts how often each of the 8 states occurs over a fixed window.
//  After the window closes it streams the 8 bin counts out over a valid/ready interface.
//  Used to compare the sampled distribution against the target Boltzmann distribution.
// PARAMETERS
//  NBITS        3     number of p-bits sampled; the block has 2**NBITS bins
//  CNT_W        16    bin counter width; counters saturate at 2**CNT_W-1
//  NUM_SAMPLES  1024  samples per window (>=1)
//  SCNT_W       11    sample counter width = $clog2(NUM_SAMPLES+1)
// PORTS
//  CLK          in   1       system clock; all logic is posedge
//  RST          in   1       asynchronous reset, active-high
//  start        in   1       pulse: clear all bins and open a window; honoured only in IDLE
//  abort        in   1       synchronous; from any state, go to IDLE next cycle; bins keep their values
//  sample_en    in   1       sample strobe; in ACCUM, captures state_in on this cycle
//  state_in     in   NBITS   p-bit outputs {out3,out2,out1}, same clock domain (no synchroniser)
//  busy         out  1       high in ACCUM or DRAIN
//  sample_cnt   out  SCNT_W  samples taken in the current window
//  hist_valid   out  1       bin data valid (DRAIN only)
//  hist_ready   in   1       consumer accepts the bin when hist_valid&hist_ready
//  hist_bin     out  NBITS   index of the bin being presented
//  hist_count   out  CNT_W   count of bin hist_bin
//  done         out  1       one-cycle pulse after the last bin is accepted
// BEHAVIOUR
//  Reset (async, RST=1): state=IDLE; all bins=0; sample_cnt=0; busy=0; hist_valid=0;
//   hist_bin=0; hist_count=0; done=0.
//  FSM: IDLE -> ACCUM -> DRAIN -> IDLE.
//  IDLE: start=1 -> all bins=0, sample_cnt=0, next state ACCUM. Other inputs are ignored.
//  ACCUM: each cycle with sample_en=1: bin[state_in] += 1, saturating at 2**CNT_W-1;
//   sample_cnt += 1. The count is visible on the cycle after the strobe.
//   On the strobe that makes sample_cnt == NUM_SAMPLES, the next state is DRAIN with
//   bin index 0. The sample on that strobe is included in the bins.
//   sample_en=0 holds all counts. start is ignored while busy.
//  DRAIN: hist_valid=1; hist_bin=idx; hist_count=bin[idx], driven from registers and
//   stable while stalled. On valid&ready: idx += 1.
//   - Accepting idx = 2**NBITS-1 -> next cycle: hist_valid=0, done=1 for one cycle,
//     state=IDLE.
//   - Back-to-back transfers are allowed: one bin per cycle when hist_ready is held high.
//   - sample_en is ignored.
//  Bins and sample_cnt keep their values in IDLE until the next start.
//  abort: takes priority over every other event, including a simultaneous start or the
//   final sample. Next cycle: IDLE, hist_valid=0, done not pulsed, no bin updated that cycle.
//  RST asserted mid-window or mid-drain: immediate return to reset values. No partial done.
//  Invariant: at DRAIN entry, the sum of all bins equals NUM_SAMPLES, unless a bin saturated.
// TESTING
//  1 NUM_SAMPLES=8; state_in=3'b101 with sample_en high 8 cycles, ready=1 ->
//    bins 0..7 streamed = 0,0,0,0,0,8,0,0 on consecutive cycles; done one cycle after bin 7.
//  2 NUM_SAMPLES=16; state_in cycles 0..7 twice with sample_en toggling 1/0 ->
//    every bin=2; sample_cnt reaches 16 only on strobe cycles.
//  3 DRAIN with hist_ready low 5 cycles at bin 3 -> hist_bin=3 and hist_count held
//    stable throughout; no bin skipped or repeated.
//  4 CNT_W=3, NUM_SAMPLES=12, state_in=0 constantly -> bin0 saturates at 7;
//    other bins=0; window still closes after 12 strobes.
//  5 abort on the cycle of the 8th of 8 strobes -> IDLE, no DRAIN, done stays 0;
//    start then clears bins and sample_cnt.
//  6 RST pulsed mid-DRAIN at bin 4 -> outputs immediately at reset values;
//    start while busy is ignored in a separate run.

Source files
------------

// File: rtl/pbit_state_histogram.sv
// pbit_state_histogram
//   Samples the p-bit network state {out3,out2,out1} on a strobe, counts how often each of the
//   2**NBITS states occurs over a window of NUM_SAMPLES strobes, then streams the bin counts out
//   over a valid/ready interface (bin 0 first, one bin per cycle at most).
//
// Ports
//   CLK         system clock, posedge
//   RST         asynchronous reset, active-high
//   start       clear all bins and open a window (honoured only when idle)
//   abort       return to idle next cycle from any state; bins keep their values
//   sample_en   sample strobe, captures state_in while accumulating
//   state_in    p-bit outputs, same clock domain
//   busy        high while accumulating or draining
//   sample_cnt  samples taken in the current window
//   hist_valid  bin data valid (drain only)
//   hist_ready  consumer accepts the presented bin
//   hist_bin    index of the presented bin
//   hist_count  count of the presented bin
//   done        one-cycle pulse after the last bin is accepted
module pbit_state_histogram #(
  parameter int unsigned NBITS       = 3,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned NUM_SAMPLES = 1024,
  parameter int unsigned SCNT_W      = 11
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              abort,
  input  logic              sample_en,
  input  logic [NBITS-1:0]  state_in,
  output logic              busy,
  output logic [SCNT_W-1:0] sample_cnt,
  output logic              hist_valid,
  input  logic              hist_ready,
  output logic [NBITS-1:0]  hist_bin,
  output logic [CNT_W-1:0]  hist_count,
  output logic              done
);

  localparam int unsigned       NumBins    = 2 ** NBITS;
  localparam logic [CNT_W-1:0]  CntMax     = '1;
  localparam logic [SCNT_W-1:0] LastSample = SCNT_W'(NUM_SAMPLES);
  localparam logic [NBITS-1:0]  LastIdx    = NBITS'(NumBins - 1);

  typedef enum logic [1:0] {StIdle, StAccum, StDrain} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bins_q [NumBins];
  logic [CNT_W-1:0]  bins_d [NumBins];
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [NBITS-1:0]  idx_q, idx_d;
  logic              done_q, done_d;

  always_comb begin
    state_d = state_q;
    bins_d  = bins_q;
    scnt_d  = scnt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    // abort beats start, the final sample and the final accept alike
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            for (int i = 0; i < int'(NumBins); i++) bins_d[i] = '0;
            scnt_d  = '0;
            idx_d   = '0;
            state_d = StAccum;
          end
        end
        StAccum: begin
          if (sample_en) begin
            if (bins_q[state_in] != CntMax) bins_d[state_in] = bins_q[state_in] + 1'b1;
            scnt_d = scnt_q + 1'b1;
            if (scnt_d == LastSample) begin
              state_d = StDrain;
              idx_d   = '0;
            end
          end
        end
        StDrain: begin
          if (hist_ready) begin
            idx_d = idx_q + 1'b1;
            if (idx_q == LastIdx) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      for (int i = 0; i < int'(NumBins); i++) bins_q[i] <= '0;
      scnt_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bins_q  <= bins_d;
      scnt_q  <= scnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Bin outputs come straight from registers, so they hold steady while the consumer stalls.
  assign busy       = (state_q != StIdle);
  assign hist_valid = (state_q == StDrain);
  assign hist_bin   = hist_valid ? idx_q : '0;
  assign hist_count = hist_valid ? bins_q[idx_q] : '0;
  assign sample_cnt = scnt_q;
  assign done       = done_q;

endmodule
